// File: rtl/semaforo_timer_car_if.sv
// Link between the traffic-light FSM and its timer/car companion.
// The FSM (master) drives the three light feedback lines and consumes the
// CAR request and TIMEOUT; the timer (slave) does the opposite.
interface semaforo_timer_car_if;
  logic GRN;
  logic YLW;
  logic RED;
  logic CAR;
  logic TIMEOUT;

  modport master (
    output GRN,
    output YLW,
    output RED,
    input  CAR,
    input  TIMEOUT
  );

  modport slave (
    input  GRN,
    input  YLW,
    input  RED,
    output CAR,
    output TIMEOUT
  );
endinterface

// File: rtl/semaforo_timer_car.sv
// Upstream companion of the traffic-light FSM.
// Conditions the raw car sensor (2-FF synchronizer, debounce, request latch),
// measures the age of the current light phase from the light feedback,
// raises TIMEOUT after a fixed red time, releases CAR only after a minimum
// green time and flags illegal light combinations with a sticky ERR.
module semaforo_timer_car #(
  parameter int W        = 8,
  parameter int RED_TIME = 20,
  parameter int MIN_GRN  = 10,
  parameter int DEB      = 3
) (
  input  logic                    clk,
  input  logic                    res,
  semaforo_timer_car_if.slave     fsm,
  input  logic                    CAR_RAW,
  output logic [W-1:0]            AGE,
  output logic                    ERR
);

  // Thresholds are compared against AGE / the debounce count, so they are
  // expressed as "last cycle index before the event" in W bits.
  localparam logic [W-1:0] L_DEB_LAST = W'(DEB - 1);
  localparam logic [W-1:0] L_RED_LAST = W'(RED_TIME - 1);
  localparam logic [W-1:0] L_GRN_LAST = W'(MIN_GRN - 1);

  logic         r_sync1;
  logic         r_sync2;
  logic [W-1:0] r_debCnt;
  logic         r_req;
  logic [2:0]   r_prevLights;
  logic [W-1:0] r_cnt;
  logic         r_err;
  logic         r_armed;

  logic [2:0]   w_lights;
  logic         w_change;
  logic         w_debDone;
  logic         w_oneHot;
  logic [W-1:0] w_age;

  assign w_lights  = {fsm.RED, fsm.YLW, fsm.GRN};
  assign w_change  = (w_lights != r_prevLights);
  assign w_debDone = r_sync2 && (r_debCnt == L_DEB_LAST);
  assign w_oneHot  = (w_lights == 3'b001) || (w_lights == 3'b010) || (w_lights == 3'b100);
  assign w_age     = w_change ? '0 : r_cnt;

  assign AGE         = w_age;
  assign ERR         = r_err;
  assign fsm.TIMEOUT = fsm.RED && (w_age >= L_RED_LAST);
  assign fsm.CAR     = fsm.GRN && r_req && (w_age >= L_GRN_LAST);

  // Two-flop synchronizer bringing the asynchronous sensor into the clock domain.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= CAR_RAW;
      r_sync2 <= r_sync1;
    end
  end

  // Debounce: count consecutive synced-high cycles, saturating so a sensor held
  // high never re-reaches the accept point and cannot re-trigger a request.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_debCnt <= '0;
    end else if (!r_sync2) begin
      r_debCnt <= '0;
    end else if (r_debCnt != '1) begin
      r_debCnt <= r_debCnt + W'(1);
    end
  end

  // Request latch: red means the car is being served, and clearing wins over a
  // debounce completion on the same edge.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_req <= 1'b0;
    end else if (fsm.RED) begin
      r_req <= 1'b0;
    end else if (w_debDone) begin
      r_req <= 1'b1;
    end
  end

  // Phase age: restart at 1 on any light change (the change cycle itself shows
  // AGE 0), otherwise count up and hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_prevLights <= 3'b000;
      r_cnt        <= '0;
    end else begin
      r_prevLights <= w_lights;
      if (w_change) begin
        r_cnt <= W'(1);
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + W'(1);
      end
    end
  end

  // Sticky illegal-lights flag; only the first edge after reset may see all
  // lights off, giving the FSM one cycle to come up.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      r_err   <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
      if (!w_oneHot && !(!r_armed && (w_lights == 3'b000))) begin
        r_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_semaforo_timer_car.sv
// Self-checking bench for semaforo_timer_car.
// A main instance (W=8) and a narrow instance (W=4) share the same stimulus.
// Expected values come from a hand-written vector table, hand-written corner
// sequences, and a run-length based reference model of the phase age, the
// debounced request and the sticky error flag.
module tb_semaforo_timer_car;

  localparam int W        = 8;
  localparam int RED_TIME = 20;
  localparam int MIN_GRN  = 10;
  localparam int DEB      = 3;
  localparam int W4       = 4;

  logic clk    = 1'b0;
  logic res    = 1'b1;
  logic grn    = 1'b0;
  logic ylw    = 1'b0;
  logic red    = 1'b0;
  logic carRaw = 1'b0;

  logic [W-1:0]  age8;
  logic          err8;
  logic [W4-1:0] age4;
  logic          err4;

  int nChecks = 0;
  int nErrors = 0;

  semaforo_timer_car_if bus8 ();
  semaforo_timer_car_if bus4 ();

  assign bus8.GRN = grn;
  assign bus8.YLW = ylw;
  assign bus8.RED = red;
  assign bus4.GRN = grn;
  assign bus4.YLW = ylw;
  assign bus4.RED = red;

  semaforo_timer_car #(.W(W), .RED_TIME(RED_TIME), .MIN_GRN(MIN_GRN), .DEB(DEB)) dut (
    .clk     (clk),
    .res     (res),
    .fsm     (bus8.slave),
    .CAR_RAW (carRaw),
    .AGE     (age8),
    .ERR     (err8)
  );

  semaforo_timer_car #(.W(W4), .RED_TIME(12), .MIN_GRN(5), .DEB(2)) dut4 (
    .clk     (clk),
    .res     (res),
    .fsm     (bus4.slave),
    .CAR_RAW (carRaw),
    .AGE     (age4),
    .ERR     (err4)
  );

  always #5 clk = ~clk;

  // Reference model state:
  //  mRun/mRunLights : how many edges the current light pattern has been seen
  //  mRr1/mRr2       : length of the raw-sensor high run after the last two edges
  //  mReq            : request pending; mErr sticky error; mFirst first edge after reset
  logic [2:0] lights;
  assign lights = {red, ylw, grn};

  int         mRun       = 0;
  logic [2:0] mRunLights = 3'b000;
  int         mRr1       = 0;
  int         mRr2       = 0;
  bit         mReq       = 1'b0;
  bit         mErr       = 1'b0;
  bit         mFirst     = 1'b1;

  // A request is accepted when the raw sensor, seen through the two-cycle
  // synchronizer, has been high for exactly DEB edges.
  always @(posedge clk or negedge res) begin
    if (!res) begin
      mRun       <= 0;
      mRunLights <= 3'b000;
      mRr1       <= 0;
      mRr2       <= 0;
      mReq       <= 1'b0;
      mErr       <= 1'b0;
      mFirst     <= 1'b1;
    end else begin
      mRun       <= (mRun != 0 && lights == mRunLights) ? mRun + 1 : 1;
      mRunLights <= lights;
      mRr1       <= carRaw ? mRr1 + 1 : 0;
      mRr2       <= mRr1;
      if (red) mReq <= 1'b0;
      else if (mRr2 == DEB) mReq <= 1'b1;
      if (!$onehot(lights) && !(mFirst && lights == 3'b000)) mErr <= 1'b1;
      mFirst <= 1'b0;
    end
  end

  function automatic int modelAge(input int cap);
    if (mRun == 0 || lights != mRunLights) return 0;
    return (mRun > cap) ? cap : mRun;
  endfunction

  function automatic bit modelCar();
    return grn && mReq && (modelAge(255) >= MIN_GRN - 1);
  endfunction

  function automatic bit modelTimeout();
    return red && (modelAge(255) >= RED_TIME - 1);
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of inputs (called just after a falling edge) and let the
  // combinational outputs settle well before the next rising edge.
  task automatic applyStimulus(input logic r, input logic g, input logic y,
                               input logic rd, input logic c);
    res    = r;
    grn    = g;
    ylw    = y;
    red    = rd;
    carRaw = c;
    #2;
  endtask

  task automatic checkOutput();
    checkVal("car",      32'(bus8.CAR),     32'(modelCar()));
    checkVal("timeout",  32'(bus8.TIMEOUT), 32'(modelTimeout()));
    checkVal("age",      32'(age8),         32'(modelAge(255)));
    checkVal("err",      32'(err8),         32'(mErr));
    checkVal("age_w4",   32'(age4),         32'(modelAge(15)));
    checkVal("err_w4",   32'(err4),         32'(mErr));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  typedef struct {
    logic res, grn, ylw, red, carRaw;
    logic expCar, expTo;
    int   expAge;
    logic expErr;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mkVec(input logic r, input logic g, input int a);
    vec_t v;
    v.res = r; v.grn = g; v.ylw = 1'b0; v.red = 1'b0; v.carRaw = 1'b0;
    v.expCar = 1'b0; v.expTo = 1'b0; v.expAge = a; v.expErr = 1'b0;
    return v;
  endfunction

  initial begin
    logic [2:0] pl;
    int         len;
    int         pick;
    bit         doReset;
    logic       raw;
    int         st;
    int         prevSt;
    int         redLen;
    bit         backToGrn;
    logic [2:0] illegal[5];

    // Reset held three cycles with green, then release: AGE 0,1,2,...
    for (int i = 0; i < 3; i++) vecs[i] = mkVec(1'b0, 1'b1, 0);
    for (int i = 3; i < 10; i++) vecs[i] = mkVec(1'b1, 1'b1, i - 3);

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].res, vecs[i].grn, vecs[i].ylw, vecs[i].red, vecs[i].carRaw);
      checkVal("tbl_car",     32'(bus8.CAR),     32'(vecs[i].expCar));
      checkVal("tbl_timeout", 32'(bus8.TIMEOUT), 32'(vecs[i].expTo));
      checkVal("tbl_age",     32'(age8),         32'(vecs[i].expAge));
      checkVal("tbl_err",     32'(err8),         32'(vecs[i].expErr));
      checkOutput();
      tick();
    end

    // Short 2-cycle sensor pulse in a long green: never accepted.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, i < 2);
      checkOutput();
      checkVal("short_pulse_car", 32'(bus8.CAR), 0);
      tick();
    end

    // Six-cycle pulse: request visible after the fifth edge (AGE already past MIN_GRN-1).
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, i < 6);
      checkOutput();
      checkVal("deb_car", 32'(bus8.CAR), 32'(i >= 5));
      tick();
    end

    // Red held 25 cycles: TIMEOUT from AGE 19. The sensor rises in red cycle 23
    // so the new request completes in green and lands at AGE 3.
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, i >= 23);
      checkOutput();
      checkVal("red_age",     32'(age8),         32'(i));
      checkVal("red_timeout", 32'(bus8.TIMEOUT), 32'(i >= RED_TIME - 1));
      tick();
    end

    // Request arriving at AGE 3 is held until AGE 9.
    for (int j = 0; j < 13; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, j <= 3);
      checkOutput();
      checkVal("mingrn_age", 32'(age8),     32'(j));
      checkVal("mingrn_car", 32'(bus8.CAR), 32'(j >= MIN_GRN - 1));
      tick();
    end

    // Illegal pattern RED+YLW for one cycle, then green: ERR sticks until reset.
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput();
    checkVal("err_before", 32'(err8), 0);
    tick();
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput();
      checkVal("err_sticky", 32'(err8), 1);
      tick();
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput();
    checkVal("err_reset", 32'(err8), 0);
    tick();

    // All lights off for one cycle after reset is tolerated.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput();
    tick();
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput();
      checkVal("err_off_1cyc", 32'(err8), 0);
      tick();
    end

    // All lights off for two cycles after reset is an error.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    for (int j = 0; j < 2; j++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput();
      tick();
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput();
    checkVal("err_off_2cyc", 32'(err8), 1);
    tick();

    // Fresh reset, then a 40-cycle green: the W=4 age saturates at 15.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput();
    tick();
    for (int j = 0; j < 40; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput();
      checkVal("w4_age", 32'(age4), 32'((j > 15) ? 15 : j));
      tick();
    end

    // Debounce completes during red (clear wins), and a sensor held high into
    // green does not produce a new request.
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, k >= 10);
      checkOutput();
      tick();
    end
    for (int j = 0; j < 15; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      checkOutput();
      checkVal("held_high_car", 32'(bus8.CAR), 0);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput();
      tick();
    end

    // Closed loop with a small FSM: green until CAR, yellow one cycle, red until TIMEOUT.
    st        = 0;
    prevSt    = 0;
    redLen    = 0;
    backToGrn = 1'b0;
    for (int c = 0; c < 120 && !backToGrn; c++) begin
      applyStimulus(1'b1, st == 0, st == 1, st == 2, c < 5);
      checkOutput();
      if (st != prevSt) checkVal("loop_age_restart", 32'(age8), 0);
      prevSt = st;
      if (st == 2) redLen++;
      case (st)
        0:       if (bus8.CAR) st = 1;
        1:       st = 2;
        default: if (bus8.TIMEOUT) begin st = 0; backToGrn = 1'b1; end
      endcase
      tick();
    end
    checkVal("loop_back_to_green", 32'(backToGrn), 1);
    checkVal("loop_red_len",       32'(redLen),    32'(RED_TIME));
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput();
    checkVal("loop_green_age", 32'(age8), 0);
    tick();

    // Randomized phases of random length, occasional illegal lights and resets.
    illegal[0] = 3'b000; illegal[1] = 3'b011; illegal[2] = 3'b101;
    illegal[3] = 3'b110; illegal[4] = 3'b111;
    raw = 1'b0;
    for (int p = 0; p < 70; p++) begin
      pick    = int'($urandom_range(0, 14));
      if (pick == 0) pl = illegal[$urandom_range(0, 4)];
      else           pl = 3'b001 << $urandom_range(0, 2);
      doReset = ($urandom_range(0, 7) == 0);
      len     = int'($urandom_range(1, 30));
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 5) == 0) raw = ~raw;
        applyStimulus(!(doReset && k < 2), pl[0], pl[1], pl[2], raw);
        checkOutput();
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
